// File: rtl/text_writer.sv
// text_writer: write-side agent for the {colour, character} text RAM.
// Accepts character bytes on a valid/ready handshake, keeps a (row, col)
// cursor and issues one-cycle RAM writes. CR, LF, BS and FF are interpreted.
// FF, or a clear_in pulse, starts a hardware sweep that writes BLANK to every
// cell.
//
// Ports:
//   CLK_108MHz, reset        clock, asynchronous active-high reset
//   char_in, color_in        character byte and its CGA attribute
//   valid_in, ready_out      input handshake (ready_out is combinational)
//   clear_in                 single-cycle clear-screen request
//   busy_out                 clear sweep in progress
//   cursor_col, cursor_row   current cursor position
//   addr, ena, wena, wdata   RAM write port (wena mirrors ena)
module text_writer #(
  parameter int unsigned COLS      = 160,
  parameter int unsigned ROWS      = 128,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] BLANK     = 16'h0720
) (
  input  logic        CLK_108MHz,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic [7:0]  color_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        clear_in,
  output logic        busy_out,
  output logic [7:0]  cursor_col,
  output logic [7:0]  cursor_row,
  output logic [15:0] addr,
  output logic        ena,
  output logic        wena,
  output logic [15:0] wdata
);

  localparam int unsigned CUR_W  = 8;
  localparam int unsigned ADDR_W = 16;

  localparam logic [CUR_W-1:0]  COL_LAST = CUR_W'(COLS - 1);
  localparam logic [CUR_W-1:0]  ROW_LAST = CUR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_W   = ADDR_W'(COLS);
  // Cell count modulo 2^16; a full 65536-cell screen wraps the counter to 0.
  localparam logic [ADDR_W-1:0] CELLS_W  = ADDR_W'(COLS * ROWS);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t             state_q,    state_d;
  logic [CUR_W-1:0]   col_q,      col_d;
  logic [CUR_W-1:0]   row_q,      row_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;   // BASE_ADDR + row*COLS
  logic [ADDR_W-1:0]  clr_cnt_q,  clr_cnt_d;
  logic [ADDR_W-1:0]  addr_q,     addr_d;
  logic [ADDR_W-1:0]  wdata_q,    wdata_d;
  logic               ena_q,      ena_d;
  logic               busy_q,     busy_d;

  logic               accept;
  logic               start_clear;
  logic               row_wrap;
  logic [CUR_W-1:0]   row_inc;
  logic [ADDR_W-1:0]  row_base_inc;

  assign ready_out  = (state_q == IDLE) & ~clear_in;
  assign accept     = valid_in & ready_out;

  assign busy_out   = busy_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign addr       = addr_q;
  assign ena        = ena_q;
  assign wena       = ena_q;
  assign wdata      = wdata_q;

  // Next row and its base address, shared by LF and end-of-line wrap.
  assign row_wrap     = (row_q == ROW_LAST);
  assign row_inc      = row_wrap ? '0 : row_q + CUR_W'(1);
  assign row_base_inc = row_wrap ? BASE_ADDR : row_base_q + COLS_W;

  // Next-state, cursor and RAM write decode.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
    clr_cnt_d   = clr_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ena_d       = 1'b0;
    busy_d      = busy_q;
    start_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_in) begin
          start_clear = 1'b1;
        end else if (accept) begin
          case (char_in)
            CH_CR: begin
              col_d = '0;
            end
            CH_LF: begin
              col_d      = '0;
              row_d      = row_inc;
              row_base_d = row_base_inc;
            end
            CH_BS: begin
              if (col_q != '0) begin
                col_d   = col_q - CUR_W'(1);
                ena_d   = 1'b1;
                addr_d  = row_base_q + ADDR_W'(col_q - CUR_W'(1));
                wdata_d = BLANK;
              end
            end
            CH_FF: begin
              start_clear = 1'b1;
            end
            default: begin
              ena_d   = 1'b1;
              addr_d  = row_base_q + ADDR_W'(col_q);
              wdata_d = {color_in, char_in};
              if (col_q == COL_LAST) begin
                col_d      = '0;
                row_d      = row_inc;
                row_base_d = row_base_inc;
              end else begin
                col_d = col_q + CUR_W'(1);
              end
            end
          endcase
        end

        // First sweep write goes out on the entry edge so it lands with busy.
        if (start_clear) begin
          state_d   = CLEAR;
          busy_d    = 1'b1;
          ena_d     = 1'b1;
          addr_d    = BASE_ADDR;
          wdata_d   = BLANK;
          clr_cnt_d = ADDR_W'(1);
        end
      end

      CLEAR: begin
        // Counter holds the index of the next cell; reaching the cell count
        // means the final write is on the bus this cycle.
        if (clr_cnt_q == CELLS_W) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          col_d      = '0;
          row_d      = '0;
          row_base_d = BASE_ADDR;
        end else begin
          ena_d     = 1'b1;
          addr_d    = BASE_ADDR + clr_cnt_q;
          wdata_d   = BLANK;
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK_108MHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= BASE_ADDR;
      clr_cnt_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ena_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      clr_cnt_q  <= clr_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ena_q      <= ena_d;
      busy_q     <= busy_d;
    end
  end

endmodule
